// File: rtl/edge_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_monitor_pkg
// Purpose  : Shared definitions for the edge monitor. Holds the per-channel
//            mode encodings, the legal parameter ranges and a helper that
//            sizes the glitch-filter counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package edge_monitor_pkg;

   // Per-channel edge-select encodings (two bits per channel)
   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;

   // Legal parameter ranges
   localparam int N_CH_MIN          = 1;
   localparam int N_CH_MAX          = 32;
   localparam int SYNC_STAGES_MIN   = 2;
   localparam int SYNC_STAGES_MAX   = 4;
   localparam int FILTER_CYCLES_MIN = 1;
   localparam int FILTER_CYCLES_MAX = 255;

   // The filter counter only has to reach FILTER_CYCLES-1, so clog2 of
   // FILTER_CYCLES bits is enough; keep at least one bit for the 1-cycle case.
   function automatic int filt_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage : edge_monitor_pkg
`default_nettype wire

// File: rtl/edge_monitor_ch.sv
`default_nettype none
// ============================================================================
// Module   : edge_monitor_ch
// Purpose  : One monitor channel: input synchronizer, glitch filter, edge
//            pulse generation, sticky pending flag and saturating counter.
// Ports    : clk        - system clock
//            reset      - synchronous active-low reset
//            i_sig      - raw asynchronous input
//            i_mode     - edge select (off / rise / fall / both)
//            i_clr      - clear pending flag and event counter
//            o_rise     - one-cycle registered rising pulse
//            o_fall     - one-cycle registered falling pulse
//            o_level    - filtered level
//            o_pending  - sticky flag, set by an enabled edge
//            o_count    - saturating count of enabled edges
// Revision : 1.0 - initial release
// ============================================================================
module edge_monitor_ch #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 3,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_sig,
   input  logic [1:0]       i_mode,
   input  logic             i_clr,
   output logic             o_rise,
   output logic             o_fall,
   output logic             o_level,
   output logic             o_pending,
   output logic [CNT_W-1:0] o_count
);
   import edge_monitor_pkg::*;

   localparam int               FILT_W      = filt_width(FILTER_CYCLES);
   localparam logic [FILT_W-1:0] C_FILT_LAST = FILT_W'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [FILT_W-1:0]      r_fcnt;
   logic                   r_level;
   logic                   r_rise;
   logic                   r_fall;
   logic                   r_pend;
   logic [CNT_W-1:0]       r_cnt;

   logic w_sy;
   logic w_update;
   logic w_rise_en;
   logic w_fall_en;
   logic w_rise_det;
   logic w_fall_det;
   logic w_event;

   assign w_sy      = r_sync[SYNC_STAGES-1];
   // Level flips only once sy has disagreed for FILTER_CYCLES edges in a row
   assign w_update  = (w_sy != r_level) && (r_fcnt == C_FILT_LAST);
   // Mode is looked at only on the update edge itself
   assign w_rise_en = (i_mode == MODE_RISE) || (i_mode == MODE_BOTH);
   assign w_fall_en = (i_mode == MODE_FALL) || (i_mode == MODE_BOTH);
   assign w_rise_det = w_update &&  w_sy && w_rise_en;
   assign w_fall_det = w_update && !w_sy && w_fall_en;
   assign w_event    = w_rise_det || w_fall_det;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync  <= '0;
         r_fcnt  <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_pend  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};

         if (w_sy == r_level) begin
            r_fcnt <= '0;
         end else if (w_update) begin
            r_level <= w_sy;
            r_fcnt  <= '0;
         end else begin
            r_fcnt <= r_fcnt + FILT_W'(1);
         end

         r_rise <= w_rise_det;
         r_fall <= w_fall_det;

         // A clear coinciding with a new edge keeps that edge: count restarts at 1
         if (i_clr && w_event) begin
            r_pend <= 1'b1;
            r_cnt  <= CNT_W'(1);
         end else if (i_clr) begin
            r_pend <= 1'b0;
            r_cnt  <= '0;
         end else if (w_event) begin
            r_pend <= 1'b1;
            if (r_cnt != {CNT_W{1'b1}}) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign o_rise    = r_rise;
   assign o_fall    = r_fall;
   assign o_level   = r_level;
   assign o_pending = r_pend;
   assign o_count   = r_cnt;

endmodule : edge_monitor_ch
`default_nettype wire

// File: rtl/edge_monitor.sv
`default_nettype none
// ============================================================================
// Module   : edge_monitor
// Purpose  : Multi-channel filtered edge monitor with per-channel pending
//            flags, saturating event counters and a combined interrupt.
// Ports    : clk          - system clock
//            reset        - synchronous active-low reset
//            signal_in    - raw asynchronous inputs, one per channel
//            mode         - 2 bits per channel edge select
//            clr          - per-channel clear of pending/counter
//            rising_edge  - one-cycle rising pulses
//            falling_edge - one-cycle falling pulses
//            level        - filtered levels
//            pending      - sticky per-channel flags
//            event_count  - per-channel counters, channel i at [i*CNT_W +: CNT_W]
//            irq          - registered OR of pending
// Revision : 1.0 - initial release
// ============================================================================
module edge_monitor #(
   parameter int N_CH          = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 3,
   parameter int CNT_W         = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_CH-1:0]       signal_in,
   input  logic [2*N_CH-1:0]     mode,
   input  logic [N_CH-1:0]       clr,
   output logic [N_CH-1:0]       rising_edge,
   output logic [N_CH-1:0]       falling_edge,
   output logic [N_CH-1:0]       level,
   output logic [N_CH-1:0]       pending,
   output logic [N_CH*CNT_W-1:0] event_count,
   output logic                  irq
);

   logic [N_CH-1:0] w_pending;
   logic            r_irq;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      edge_monitor_ch #(
         .SYNC_STAGES   (SYNC_STAGES),
         .FILTER_CYCLES (FILTER_CYCLES),
         .CNT_W         (CNT_W)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .i_sig     (signal_in[gi]),
         .i_mode    (mode[2*gi +: 2]),
         .i_clr     (clr[gi]),
         .o_rise    (rising_edge[gi]),
         .o_fall    (falling_edge[gi]),
         .o_level   (level[gi]),
         .o_pending (w_pending[gi]),
         .o_count   (event_count[gi*CNT_W +: CNT_W])
      );
   end

   // irq trails pending by one cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |w_pending;
      end
   end

   assign pending = w_pending;
   assign irq     = r_irq;

endmodule : edge_monitor
`default_nettype wire

// File: tb/tb_edge_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_monitor
// Purpose  : Self-checking bench for edge_monitor (N_CH=4, SYNC_STAGES=2,
//            FILTER_CYCLES=3, CNT_W=8): a cycle-by-cycle vector table plus
//            directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  signal_in;
   logic [7:0]  mode;
   logic [3:0]  clr;
   logic [3:0]  rising_edge;
   logic [3:0]  falling_edge;
   logic [3:0]  level;
   logic [3:0]  pending;
   logic [31:0] event_count;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   edge_monitor #(
      .N_CH          (4),
      .SYNC_STAGES   (2),
      .FILTER_CYCLES (3),
      .CNT_W         (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .signal_in    (signal_in),
      .mode         (mode),
      .clr          (clr),
      .rising_edge  (rising_edge),
      .falling_edge (falling_edge),
      .level        (level),
      .pending      (pending),
      .event_count  (event_count),
      .irq          (irq)
   );

   typedef struct {
      logic       rst_n;
      logic [3:0] sig;
      logic [3:0] e_rise;
      logic [3:0] e_fall;
      logic [3:0] e_lvl;
      logic [3:0] e_pend;
      logic       e_irq;
      logic [7:0] e_c0;
      logic [7:0] e_c1;
   } vec_t;

   vec_t tbl [21];

   function automatic vec_t mkv(input logic r, input logic [3:0] s, input logic [3:0] ri,
                                input logic [3:0] fa, input logic [3:0] lv, input logic [3:0] pe,
                                input logic iq, input logic [7:0] c0, input logic [7:0] c1);
      vec_t v;
      v.rst_n = r;  v.sig = s;   v.e_rise = ri; v.e_fall = fa; v.e_lvl = lv;
      v.e_pend = pe; v.e_irq = iq; v.e_c0 = c0; v.e_c1 = c1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] cnt(input int ch);
      return event_count[ch*8 +: 8];
   endfunction

   int rises;
   int falls;
   int stray;

   initial begin
      reset     = 1'b0;
      signal_in = 4'b0000;
      mode      = 8'h0D;   // ch0 rise, ch1 both, ch2/ch3 off
      clr       = 4'b0000;

      // ---- vector table: row i drives inputs, clocks once, checks outputs
      tbl[0] = mkv(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'd0, 8'd0);
      tbl[1] = mkv(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'd0, 8'd0);
      for (int i = 2; i <= 5; i++)
         tbl[i] = mkv(1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'd0, 8'd0);
      // fifth edge after first sample: rise pulse, level, pending, count
      tbl[6] = mkv(1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0, 8'd1, 8'd0);
      for (int i = 7; i <= 18; i++)
         tbl[i] = mkv(1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b1, 8'd1, 8'd0);
      // ch1: 2-cycle glitch (rows 9-10), then 3+ cycles high from row 15
      tbl[9].sig  = 4'b0011;
      tbl[10].sig = 4'b0011;
      for (int i = 15; i <= 18; i++) tbl[i].sig = 4'b0011;
      tbl[19] = mkv(1'b1, 4'b0011, 4'b0010, 4'b0000, 4'b0011, 4'b0011, 1'b1, 8'd1, 8'd1);
      tbl[20] = mkv(1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 4'b0011, 1'b1, 8'd1, 8'd1);

      for (int i = 0; i < 21; i++) begin
         reset     = tbl[i].rst_n;
         signal_in = tbl[i].sig;
         step();
         check($sformatf("row%0d rise", i),    rising_edge,  tbl[i].e_rise);
         check($sformatf("row%0d fall", i),    falling_edge, tbl[i].e_fall);
         check($sformatf("row%0d level", i),   level,        tbl[i].e_lvl);
         check($sformatf("row%0d pending", i), pending,      tbl[i].e_pend);
         check($sformatf("row%0d irq", i),     irq,          tbl[i].e_irq);
         check($sformatf("row%0d cnt0", i),    cnt(0),       tbl[i].e_c0);
         check($sformatf("row%0d cnt1", i),    cnt(1),       tbl[i].e_c1);
      end

      // ---- ch2 falling-only, 300 full toggles, counter saturates at 255
      mode  = 8'hED;       // ch0 rise, ch1 both, ch2 fall, ch3 both
      rises = 0;
      falls = 0;
      for (int k = 1; k <= 300; k++) begin
         signal_in[2] = 1'b1;
         repeat (6) begin
            step();
            if (rising_edge[2])  rises++;
            if (falling_edge[2]) falls++;
         end
         signal_in[2] = 1'b0;
         repeat (6) begin
            step();
            if (rising_edge[2])  rises++;
            if (falling_edge[2]) falls++;
         end
         if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300)
            check($sformatf("sat cnt2 after %0d", k), cnt(2), (k > 255) ? 255 : k);
      end
      check("sat ch2 rising pulses", rises, 0);
      check("sat ch2 falling pulses", falls, 300);
      check("sat ch2 pending", pending[2], 1'b1);
      check("sat ch0 cnt untouched", cnt(0), 8'd1);

      // ---- ch3: count to 7, then clr on the falling update edge
      for (int k = 0; k < 3; k++) begin
         signal_in[3] = 1'b1; repeat (6) step();
         signal_in[3] = 1'b0; repeat (6) step();
      end
      signal_in[3] = 1'b1; repeat (6) step();
      check("clr ch3 cnt before", cnt(3), 8'd7);
      signal_in[3] = 1'b0;
      repeat (4) step();
      check("clr ch3 level pre-update", level[3], 1'b1);
      clr = 4'b1000;
      step();
      clr = 4'b0000;
      check("clr ch3 fall pulse", falling_edge[3], 1'b1);
      check("clr ch3 pending", pending[3], 1'b1);
      check("clr ch3 cnt", cnt(3), 8'd1);
      clr = 4'b1000;
      step();
      clr = 4'b0000;
      check("clr ch3 pending cleared", pending[3], 1'b0);
      check("clr ch3 cnt cleared", cnt(3), 8'd0);

      // ---- irq lags pending by one cycle
      clr = 4'b1111;
      step();
      clr = 4'b0000;
      check("irq pending all clear", pending, 4'b0000);
      check("irq still high (lag)", irq, 1'b1);
      step();
      check("irq low after lag", irq, 1'b0);

      // ---- all channels both edges, simultaneous toggle, then reset abort
      mode      = 8'hFF;
      signal_in = 4'b0000;
      repeat (6) step();
      signal_in = 4'b1111;
      repeat (4) step();
      check("sim level before", level, 4'b0000);
      step();
      check("sim rise all", rising_edge, 4'b1111);
      check("sim level all", level, 4'b1111);
      step();
      check("sim rise one cycle", rising_edge, 4'b0000);
      signal_in = 4'b0000;
      repeat (3) step();   // falling change is mid-filter here
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("rst rise", rising_edge, 4'b0000);
      check("rst fall", falling_edge, 4'b0000);
      check("rst level", level, 4'b0000);
      check("rst pending", pending, 4'b0000);
      check("rst counts", event_count, 32'h0);
      check("rst irq", irq, 1'b0);
      stray = 0;
      repeat (10) begin
         step();
         if (rising_edge != 4'b0000 || falling_edge != 4'b0000 || level != 4'b0000) stray++;
      end
      check("rst no stray activity", stray, 0);
      check("rst pending stays clear", pending, 4'b0000);

      // ---- ch0 mode off: level tracks, nothing else
      mode         = 8'hFC;
      signal_in[0] = 1'b1;
      stray        = 0;
      repeat (6) begin
         step();
         if (rising_edge[0]) stray++;
      end
      check("off ch0 level", level[0], 1'b1);
      check("off ch0 no pulse", stray, 0);
      check("off ch0 pending", pending[0], 1'b0);
      check("off ch0 cnt", cnt(0), 8'd0);
      check("off irq", irq, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_edge_monitor
`default_nettype wire

// File: doc/edge_monitor.md
EDGE_MONITOR -- requirements
Module: edge_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops per channel (2..4).
REQ-003 SHALL have parameter FILTER_CYCLES, default 3: consecutive stable cycles needed to accept a level change (1..255).
REQ-004 SHALL have parameter CNT_W, default 8: width of each per-channel event counter.
REQ-005 SHALL have port clk, input, 1: single system clock; all logic on posedge clk.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port signal_in, input, N_CH: asynchronous raw inputs.
REQ-008 SHALL have port mode, input, 2*N_CH: per-channel edge select; bits [2i+1:2i] = 00 off, 01 rising, 10 falling, 11 both.
REQ-009 SHALL have port clr, input, N_CH: per-channel clear of the pending flag and event counter.
REQ-010 SHALL have port rising_edge, output, N_CH: one-cycle registered rising pulse.
REQ-011 SHALL have port falling_edge, output, N_CH: one-cycle registered falling pulse.
REQ-012 SHALL have port level, output, N_CH: filtered level per channel.
REQ-013 SHALL have port pending, output, N_CH: sticky flag per channel, set by an enabled edge.
REQ-014 SHALL have port event_count, output, N_CH*CNT_W: per-channel saturating count of enabled edges; channel i occupies [i*CNT_W +: CNT_W].
REQ-015 SHALL have port irq, output, 1: registered OR of pending.

Function
REQ-016 Each channel SHALL pass signal_in[i] through SYNC_STAGES flops; the last stage is sy[i].
REQ-017 The filter SHALL behave as follows. If sy equals level, the counter clears to 0. Otherwise, if the counter equals FILTER_CYCLES-1, level takes sy and the counter clears to 0. Otherwise the counter increments.
REQ-018 A deviation of sy shorter than FILTER_CYCLES consecutive cycles SHALL leave level unchanged and produce no pulse.
REQ-019 On the edge where level updates 0->1, rising_edge[i] SHALL be registered high for exactly one cycle if mode bit 2i=1. The 1->0 update SHALL do the same for falling_edge[i] if mode bit 2i+1=1.
REQ-020 Latency SHALL be fixed: input change first sampled at edge 1 -> pulse high in the cycle after edge SYNC_STAGES+FILTER_CYCLES.
REQ-021 Mode SHALL be sampled on the update edge only. With mode 00, level still tracks the input, but no pulse, pending or count change occurs.
REQ-022 An enabled edge SHALL set pending[i] and increment event_count[i]. The count saturates at 2^CNT_W-1 and does not wrap.
REQ-023 clr[i] SHALL clear pending[i] and event_count[i] on the next edge.
REQ-024 If clr[i] and an enabled edge occur on the same edge, the result SHALL be pending[i]=1 and event_count[i]=1.
REQ-025 irq SHALL equal the OR of pending, registered, and lag pending by one cycle.
REQ-026 Channels SHALL be fully independent; simultaneous edges on all channels are all captured.

Reset
REQ-027 While reset=0 at posedge clk, all registers SHALL clear: sync flops, level, filter counters, rising_edge, falling_edge, pending, event_count and irq all 0.
REQ-028 After reset release with signal_in[i] held high, a rising edge SHALL be detected after the REQ-020 latency; this is defined behaviour.
REQ-029 Reset asserted mid-filter or mid-pulse SHALL abort the operation; no pulse appears after release until a fresh qualified change.

Structure
REQ-030 Package edge_monitor_pkg SHALL hold the mode encodings (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) and parameter-range constants.
REQ-031 Per-channel logic SHALL live in one sub-module, edge_monitor_ch (sync, filter, edge, pending, counter), instantiated N_CH times by generate. Top level holds only the irq OR-reduce and register.

Verification (N_CH=4, SYNC_STAGES=2, FILTER_CYCLES=3, CNT_W=8)
REQ-032 Ch0 mode=01, signal_in[0] 0->1 held -> rising_edge[0] high exactly one cycle, 5 edges after first sample; level[0]=1; pending[0]=1; count=1; irq=1 one cycle after pending.
REQ-033 Ch1 mode=11, 2-cycle high glitch then low -> no pulse, level[1]=0, count=0. A subsequent 3-cycle high -> rising pulse.
REQ-034 Ch2 mode=10, 300 full toggles -> falling pulses only; event_count[2] saturates at 255.
REQ-035 Ch3 mode=11, clr[3] asserted on the same edge as a falling update with count=7 -> pending[3]=1, count=1.
REQ-036 All channels mode=11, toggle simultaneously, then reset=0 for 1 cycle mid-filter -> all outputs 0, no stray pulse afterwards. Channel 0 mode=00 -> level follows, no pulse, no count.
